// File: rtl/univ_shift_reg_pkg.sv
// univ_shift_reg_pkg: mode encodings shared by the shift register and its bit slices
package univ_shift_reg_pkg;
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;
endpackage

// File: rtl/usr_bit.sv
// usr_bit: one register bit with its 4:1 hold/shift-right/shift-left/load next-state mux
module usr_bit
  import univ_shift_reg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rst_val,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       shr_src,
  input  logic       shl_src,
  input  logic       d,
  output logic       q
);
  logic bit_d, bit_q;
  // select the next value of this bit; disabled or hold keeps the current value
  always_comb begin
    bit_d = !en                ? bit_q   :
            mode == MODE_SHR   ? shr_src :
            mode == MODE_SHL   ? shl_src :
            mode == MODE_LOAD  ? d       : bit_q;
  end
  // state flop with synchronous reset taking priority over everything else
  always_ff @(posedge clk) begin
    bit_q <= rst ? rst_val : bit_d;
  end
  assign q = bit_q;
endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: universal shift register; define UNIV_SHIFT_REG_ROTATE_EN to let rot wrap edge bits
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sr_in,
  input  logic             sl_in,
  input  logic [WIDTH-1:0] D,
  input  logic             rot,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] q,
  output logic             zero
);
  logic             msb_in, lsb_in;
  logic [WIDTH:0]   shr_cat, shl_cat;
  logic [WIDTH-1:0] shr_src, shl_src;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
  // with rotate selected the bit shifted out re-enters at the opposite end
  always_comb begin
    msb_in = rot ? Q[0] : sr_in;
    lsb_in = rot ? Q[WIDTH-1] : sl_in;
  end
`else
  logic unused_rot;
  assign unused_rot = rot;
  // plain shifting: edge bits come straight from the serial inputs
  always_comb begin
    msb_in = sr_in;
    lsb_in = sl_in;
  end
`endif
  // neighbour taps per bit; the extra concat bit keeps WIDTH=1 legal
  always_comb begin
    shr_cat = {msb_in, Q};
    shl_cat = {Q, lsb_in};
    shr_src = shr_cat[WIDTH:1];
    shl_src = shl_cat[WIDTH-1:0];
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    usr_bit u_bit (
      .clk     (clk),
      .rst     (rst),
      .rst_val (RESET_VAL[i]),
      .en      (en),
      .mode    (mode),
      .shr_src (shr_src[i]),
      .shl_src (shl_src[i]),
      .d       (D[i]),
      .q       (Q[i])
    );
  end
  assign q    = ~Q;
  assign zero = ~|Q;
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed checks of reset, load/hold, shifts, rotate and mid-shift reset
module tb_univ_shift_reg;
  import univ_shift_reg_pkg::*;
  logic       clk = 0;
  logic       rst, en, sr_in, sl_in, rot;
  logic [1:0] mode;
  logic [7:0] d;
  logic [7:0] qa_o, qa_n, qz_o, qz_n;
  logic       za, zz;
  logic [0:0] q1_o, q1_n, d1;
  logic       z1;
  int         checks = 0;
  int         failures = 0;
  always #5 clk = ~clk;
  assign d1 = d[0:0];
  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sr_in(sr_in), .sl_in(sl_in),
    .D(d), .rot(rot), .Q(qa_o), .q(qa_n), .zero(za));
  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut_z (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sr_in(sr_in), .sl_in(sl_in),
    .D(d), .rot(rot), .Q(qz_o), .q(qz_n), .zero(zz));
  univ_shift_reg #(.WIDTH(1), .RESET_VAL(1'b0)) dut_1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sr_in(sr_in), .sl_in(sl_in),
    .D(d1), .rot(rot), .Q(q1_o), .q(q1_n), .zero(z1));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [7:0] shr_exp [8];
    shr_exp = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00};
    rst = 1; en = 1; mode = MODE_LOAD; d = 8'hFF; sr_in = 0; sl_in = 0; rot = 0;
    step();
    chk("rst_Q", qa_o, 8'hA5);
    chk("rst_q", qa_n, 8'h5A);
    chk("rst_zero", za, 0);
    chk("rst0_Q", qz_o, 8'h00);
    chk("rst0_zero", zz, 1);
    chk("rst0_q", qz_n, 8'hFF);
    chk("rst_w1", q1_o, 0);
    step();
    chk("rst_hold", qa_o, 8'hA5);
    rst = 0; d = 8'h3C;
    step();
    chk("load", qa_o, 8'h3C);
    en = 0; d = 8'hFF; sl_in = 1; sr_in = 1; rot = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("en0_hold", qa_o, 8'h3C);
    end
    en = 1; mode = MODE_HOLD;
    step();
    chk("mode_hold", qa_o, 8'h3C);
    rot = 0; sr_in = 0; sl_in = 0; mode = MODE_LOAD; d = 8'h81;
    step();
    chk("load81", qa_o, 8'h81);
    mode = MODE_SHR;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("shr", qa_o, shr_exp[i]);
      chk("shr_zero", za, i == 7);
    end
    mode = MODE_SHL; sl_in = 1;
    step(); chk("shl1", qa_o, 8'h01);
    step(); chk("shl2", qa_o, 8'h03);
    step(); chk("shl3", qa_o, 8'h07);
    mode = MODE_LOAD; d = 8'h81; sl_in = 0;
    step();
    rot = 1; mode = MODE_SHL;
    step();
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    chk("rotl", qa_o, 8'h03);
`else
    chk("rotl_off", qa_o, 8'h02);
`endif
    mode = MODE_SHR;
    step();
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    chk("rotr", qa_o, 8'h81);
`else
    chk("rotr_off", qa_o, 8'h01);
`endif
    rot = 0; mode = MODE_LOAD; d = 8'h81;
    step();
    mode = MODE_SHR; sr_in = 0;
    step(); chk("mid_shr1", qz_o, 8'h40);
    step(); chk("mid_shr2", qz_o, 8'h20);
    step(); chk("mid_shr3", qz_o, 8'h10);
    rst = 1;
    step();
    chk("mid_rst_Q", qz_o, 8'h00);
    chk("mid_rst_zero", zz, 1);
    chk("mid_rst_A5", qa_o, 8'hA5);
    rst = 0; mode = MODE_SHL; sl_in = 1;
    step();
    chk("post_rst_shl", qz_o, 8'h01);
    chk("post_rst_shl_a", qa_o, 8'h4B);
    mode = MODE_SHR; sr_in = 1; sl_in = 0;
    step();
    chk("w1_shr", q1_o, 1);
    chk("w1_zero", z1, 0);
    chk("shr_in1", qa_o, 8'hA5);
    mode = MODE_SHL; sr_in = 1; sl_in = 0;
    step();
    chk("w1_shl", q1_o, 0);
    chk("shl_in0", qa_o, 8'h4A);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, register width in bits; legal range 1..64.
REQ-002 The block SHALL have parameter RESET_VAL, default 0, a WIDTH-bit value loaded into Q by reset.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-005 The block SHALL have port en, input, 1 bit, clock enable; 0 means hold.
REQ-006 The block SHALL have port mode, input, 2 bits: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 The block SHALL have port sr_in, input, 1 bit, serial data entering the MSB on shift right.
REQ-008 The block SHALL have port sl_in, input, 1 bit, serial data entering the LSB on shift left.
REQ-009 The block SHALL have port D, input, WIDTH bits, parallel load data.
REQ-010 The block SHALL have port rot, input, 1 bit, rotate select; used only under REQ-024.
REQ-011 The block SHALL have port Q, output, WIDTH bits, register contents.
REQ-012 The block SHALL have port q, output, WIDTH bits, bitwise complement of Q.
REQ-013 The block SHALL have port zero, output, 1 bit, high when Q equals all zeros.

Function
REQ-014 Q SHALL be the only state; q and zero SHALL be combinational from Q with zero latency.
REQ-015 With en=1 and mode=01, the block SHALL update Q to {sr_in, Q[WIDTH-1:1]} on the next edge.
REQ-016 With en=1 and mode=10, the block SHALL update Q to {Q[WIDTH-2:0], sl_in} on the next edge.
REQ-017 With en=1 and mode=11, the block SHALL update Q to D on the next edge (1-cycle latency).
REQ-018 With en=0 or mode=00, the block SHALL hold Q unchanged regardless of D, sl_in, sr_in and rot.
REQ-019 For WIDTH=1, shift right SHALL give Q=sr_in and shift left SHALL give Q=sl_in.
REQ-020 Shifted-out bits SHALL be discarded; no wrap-around unless REQ-024 applies.

Reset
REQ-021 When rst=1 at a rising edge, the block SHALL set Q to RESET_VAL, so q=~RESET_VAL and zero=(RESET_VAL==0).
REQ-022 rst SHALL take priority over en and mode, including in the middle of a shift sequence; the first enabled operation after rst falls SHALL act on RESET_VAL.
REQ-023 The block SHALL NOT use any asynchronous reset path; before the first reset edge, Q is undefined.

Configuration
REQ-024 With macro UNIV_SHIFT_REG_ROTATE_EN defined and rot=1, shift right SHALL load Q[0] into the MSB and shift left SHALL load Q[WIDTH-1] into the LSB, ignoring sr_in and sl_in.
REQ-025 Without UNIV_SHIFT_REG_ROTATE_EN, the rot port SHALL remain present but be ignored, and the shift behaviour SHALL follow REQ-015 and REQ-016 only.

Structure
REQ-026 The mode encodings (MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD) SHALL be constants in the shared package univ_shift_reg_pkg.
REQ-027 The per-bit 4:1 next-state mux and flop SHALL be the sub-module usr_bit, instantiated WIDTH times; the top level SHALL handle edge-bit serial and rotate selection.

Verification
REQ-028 Reset: WIDTH=8, RESET_VAL=8'hA5, rst=1 for one edge -> Q=A5, q=5A, zero=0; hold rst=1 with en=1, mode=11, D=FF -> Q stays A5.
REQ-029 Load and hold: mode=11, D=8'h3C, en=1 -> Q=3C after 1 edge; then en=0 for 3 edges with D=FF -> Q stays 3C.
REQ-030 Shift right: from Q=8'h81, mode=01, sr_in=0, 8 edges -> Q goes 40, 20, 10, 08, 04, 02, 01, 00, and zero rises on the 8th edge.
REQ-031 Shift left: from Q=8'h00, mode=10, sl_in=1, 3 edges -> Q goes 01, 03, 07.
REQ-032 Rotate (macro defined): Q=8'h81, rot=1, mode=10, 1 edge -> Q=03; mode=01, 1 edge -> Q=81. With the macro undefined, the same stimulus with sl_in=0 -> Q=02.
REQ-033 Reset mid-shift: during the REQ-030 sequence, rst=1 at edge 4 with RESET_VAL=0 -> Q=00, zero=1; the next shift-left edge with sl_in=1 -> Q=01.
